// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the access FSM states, funct3 width codes and the fault rule.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_REQ   = 3'd1,
        LD_RESP  = 3'd2,
        RMW_REQ  = 3'd3,
        RMW_RESP = 3'd4,
        WR       = 3'd5,
        DONE     = 3'd6
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f_is_fault(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic flt;
        flt = 1'b0;
        unique case (f3)
            F3_B, F3_BU: flt = 1'b0;
            F3_H, F3_HU: flt = off[0];
            F3_W:        flt = (off != 2'b00);
            default:     flt = 1'b1;
        endcase
        // Unsigned codes only make sense for loads
        if (we && f3[2]) begin
            flt = 1'b1;
        end
        return flt;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: load extract/extend and sub-word store merge.
// Purely combinational; little-endian byte lanes.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [15:0]       i_wdata,
    input  logic [1:0]        i_off,
    input  logic [2:0]        i_funct3,
    output logic [DATA_W-1:0] o_ld_res,
    output logic [DATA_W-1:0] o_st_word
);

    logic [DATA_W-1:0] w_sh;
    logic [7:0]        w_b;
    logic [15:0]       w_h;

    always_comb begin
        w_sh     = i_word >> {i_off, 3'b000};
        w_b      = w_sh[7:0];
        w_h      = w_sh[15:0];
        o_ld_res = i_word;
        unique case (i_funct3)
            F3_B:    o_ld_res = {{24{w_b[7]}}, w_b};
            F3_BU:   o_ld_res = {24'h0, w_b};
            F3_H:    o_ld_res = {{16{w_h[15]}}, w_h};
            F3_HU:   o_ld_res = {16'h0, w_h};
            default: o_ld_res = i_word;
        endcase
    end

    always_comb begin
        o_st_word = i_word;
        unique case (i_funct3)
            F3_B:    o_st_word[{i_off, 3'b000} +: 8] = i_wdata[7:0];
            F3_H:    o_st_word[{i_off[1], 4'b0000} +: 16] = i_wdata;
            default: o_st_word = i_word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator for a single-port word-wide data memory.
// Sub-word stores run read-modify-write; faults skip memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_stall,
    output logic              o_ld_valid,
    output logic [DATA_W-1:0] o_ld_data,
    output logic              o_fault,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [DATA_W-1:0] o_st_data,
    output logic              o_lsu_wren,
    input  logic [DATA_W-1:0] i_ld_data
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;
    logic [1:0]        r_off;
    logic [2:0]        r_f3;
    logic [15:0]       r_wdata;
    logic              r_ld_valid;
    logic [DATA_W-1:0] r_ld_data;
    logic              r_fault;
    logic [ADDR_W-1:0] r_lsu_addr;
    logic [DATA_W-1:0] r_st_data;
    logic              r_lsu_wren;

    logic              w_acc;
    logic              w_ld_valid_n;
    logic [DATA_W-1:0] w_ld_data_n;
    logic              w_fault_n;
    logic [ADDR_W-1:0] w_lsu_addr_n;
    logic [DATA_W-1:0] w_st_data_n;
    logic              w_lsu_wren_n;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_ld_res;
    logic [DATA_W-1:0] w_st_word;

    assign w_waddr = {i_addr[ADDR_W-1:2], 2'b00};

    lsu_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .i_word   (i_ld_data),
        .i_wdata  (r_wdata),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_ld_res (w_ld_res),
        .o_st_word(w_st_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_off      <= 2'b00;
            r_f3       <= 3'b000;
            r_wdata    <= 16'h0;
            r_ld_valid <= 1'b0;
            r_ld_data  <= '0;
            r_fault    <= 1'b0;
            r_lsu_addr <= '0;
            r_st_data  <= '0;
            r_lsu_wren <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ld_valid <= w_ld_valid_n;
            r_ld_data  <= w_ld_data_n;
            r_fault    <= w_fault_n;
            r_lsu_addr <= w_lsu_addr_n;
            r_st_data  <= w_st_data_n;
            r_lsu_wren <= w_lsu_wren_n;
            if (w_acc) begin
                r_off   <= i_addr[1:0];
                r_f3    <= i_funct3;
                r_wdata <= i_wdata[15:0];
            end
        end
    end

    // Outputs for the next state are computed here and registered
    always_comb begin
        w_state_nxt  = r_state;
        w_acc        = 1'b0;
        w_ld_valid_n = 1'b0;
        w_fault_n    = 1'b0;
        w_ld_data_n  = r_ld_data;
        w_lsu_addr_n = r_lsu_addr;
        w_st_data_n  = r_st_data;
        w_lsu_wren_n = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_req) begin
                    w_acc = 1'b1;
                    if (f_is_fault(i_we, i_funct3, i_addr[1:0])) begin
                        w_state_nxt = DONE;
                        w_fault_n   = 1'b1;
                        w_ld_data_n = '0;
                    end else if (!i_we) begin
                        w_state_nxt  = LD_REQ;
                        w_lsu_addr_n = w_waddr;
                    end else if (i_funct3 == F3_W) begin
                        w_state_nxt  = WR;
                        w_lsu_addr_n = w_waddr;
                        w_st_data_n  = i_wdata;
                        w_lsu_wren_n = 1'b1;
                    end else begin
                        w_state_nxt  = RMW_REQ;
                        w_lsu_addr_n = w_waddr;
                    end
                end
            end
            LD_REQ:  w_state_nxt = LD_RESP;
            LD_RESP: begin
                w_state_nxt  = DONE;
                w_ld_valid_n = 1'b1;
                w_ld_data_n  = w_ld_res;
            end
            RMW_REQ: w_state_nxt = RMW_RESP;
            RMW_RESP: begin
                w_state_nxt  = WR;
                w_st_data_n  = w_st_word;
                w_lsu_wren_n = 1'b1;
            end
            WR:      w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_stall = (r_state == LD_REQ) || (r_state == LD_RESP) ||
                     (r_state == RMW_REQ) || (r_state == RMW_RESP) ||
                     (r_state == WR) || ((r_state == IDLE) && i_req);

    assign o_ld_valid = r_ld_valid;
    assign o_ld_data  = r_ld_data;
    assign o_fault    = r_fault;
    assign o_lsu_addr = r_lsu_addr;
    assign o_st_data  = r_st_data;
    assign o_lsu_wren = r_lsu_wren;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Core-side load/store initiator that drives the single-port word-wide data memory (dmem).
- dmem offers word writes only and a registered read that is valid one cycle after the address.
- lsu_ctrl handles byte/halfword/word loads with sign or zero extension.
- Sub-word stores use a read-modify-write sequence; misaligned or illegal accesses are reported as faults.
- The core stalls on o_stall until the access completes.

Parameters:
- ADDR_W, 32, width of the core address and the memory address.
- DATA_W, 32, data width; fixed at 32 (RV32).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req  in  1  core requests an access this cycle; held until o_stall=0.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_stall  out  1  core must hold its current instruction.
- o_ld_valid  out  1  o_ld_data is valid this cycle.
- o_ld_data  out  32  extended load result.
- o_fault  out  1  misaligned or illegal access, one-cycle pulse.
- o_lsu_addr  out  32  word address to dmem, bits [1:0] = 00.
- o_st_data  out  32  full word to write to dmem.
- o_lsu_wren  out  1  dmem write enable.
- i_ld_data  in  32  dmem read word; valid the cycle after o_lsu_addr is presented with o_lsu_wren=0.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - o_ld_valid, o_ld_data, o_fault, o_lsu_addr, o_st_data, o_lsu_wren all 0.
  - Reset wins over any in-flight access; no write is issued after reset is seen.
- All outputs except o_stall are registered.
- o_stall is combinational: 1 when state is in {LD_REQ, LD_RESP, RMW_REQ, RMW_RESP, WR}, or when (state==IDLE and i_req); otherwise 0.
- Requests are sampled only in IDLE. i_req during DONE is ignored (it is the same instruction).
- Request capture on acceptance in IDLE: addr, wdata, funct3, we.
- Fault check in IDLE:
  - H/HU with addr[0]=1 is a fault.
  - W with addr[1:0]!=00 is a fault.
  - funct3 in {011, 110, 111} is a fault.
  - A store with funct3[2]=1 is a fault.
  - On fault: go to DONE with o_fault=1, o_ld_valid=0, o_ld_data=0; no memory access.
- State transitions:
  - IDLE -> LD_REQ for a load.
  - IDLE -> WR for a store word.
  - IDLE -> RMW_REQ for a store byte/half.
  - IDLE -> DONE on fault.
  - LD_REQ: o_lsu_addr = {addr[31:2],00}, o_lsu_wren=0 -> LD_RESP.
  - LD_RESP: select byte/half from i_ld_data by addr[1:0], extend per funct3, register into o_ld_data -> DONE with o_ld_valid=1.
  - RMW_REQ: same as LD_REQ -> RMW_RESP.
  - RMW_RESP: merge wdata[7:0] (lane addr[1:0]) or wdata[15:0] (lane addr[1]) into i_ld_data; latch into o_st_data -> WR.
  - WR: o_lsu_wren=1 for exactly one cycle, o_lsu_addr set, o_st_data = word (SW) or merged word -> DONE.
  - DONE: o_ld_valid/o_fault held for this one cycle -> IDLE. Both clear on leaving DONE.
- Latencies, counted in cycles from the accept cycle through DONE (o_stall=0 in DONE):
  - Load: 4.
  - SW: 3.
  - SB/SH: 5.
  - Fault: 2.
- Little-endian lanes: byte k = bits [8k+7:8k].
- o_lsu_wren is 0 in every state except WR.

Decomposition:
- Package lsu_pkg holds:
  - state enum (IDLE, LD_REQ, LD_RESP, RMW_REQ, RMW_RESP, WR, DONE);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One combinational sub-module lsu_align:
  - load extract/extend: word, addr[1:0], funct3 -> result;
  - store merge: old word, wdata, addr[1:0], funct3 -> new word.

Test Plan:
- Word load: mem[3]=0xDEADBEEF; LW addr 0x0C -> o_lsu_addr=0x0C in LD_REQ; o_ld_valid=1, o_ld_data=0xDEADBEEF 3 cycles after accept; o_stall low only in DONE.
- Byte loads: mem[1]=0x80FF7F01; LB 0x07 -> 0xFFFFFF80; LBU 0x07 -> 0x00000080; LH 0x04 -> 0x00007F01; LHU 0x06 -> 0x000080FF.
- SB read-modify-write: mem[2]=0x11223344; SB 0x09 with wdata=0xAB -> exactly one o_lsu_wren pulse, o_st_data=0x1122AB44, addr 0x08; then LW 0x08 returns 0x1122AB44.
- Misaligned/illegal faults:
  - LW 0x05 -> o_fault=1 one cycle after accept, no wren, o_ld_valid=0;
  - SH 0x03 -> same;
  - funct3=011 -> same.
- Reset mid-op: assert i_reset during RMW_RESP of SH 0x10 -> next cycle state IDLE, all outputs 0, no write to mem[4].
- Back-to-back: SW 0x00 = 0x12345678 then LW 0x00 with i_req held continuously -> second access accepted in the IDLE cycle after DONE, returns 0x12345678.
